// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words
// and flags whether they match the values this image was built against.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1488914704,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StRdId, StRdTs, StCheck, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        auto_q, auto_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            auto_q     <= AUTO_START;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            auto_q     <= auto_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        auto_d     = auto_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        unique case (state_q)
            StIdle: begin
                // The pending auto-start behaves exactly like a start pulse, once per reset.
                if (start || auto_q) begin
                    state_d = StRdId;
                    cnt_d   = '0;
                    auto_d  = 1'b0;
                end
            end
            StRdId: begin
                if (!avm_waitrequest) begin
                    id_value_d = avm_readdata;
                    state_d    = StRdTs;
                    cnt_d      = '0;
                end else if (cnt_q == CntLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRdTs: begin
                if (!avm_waitrequest) begin
                    ts_value_d = avm_readdata;
                    state_d    = StCheck;
                end else if (cnt_q == CntLast) begin
                    // All-or-nothing: a partial read never reports a good ID.
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCheck: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP);
                state_d = StDone;
            end
            StDone: begin
                if (start) begin
                    state_d   = StRdId;
                    cnt_d     = '0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        avm_read    = (state_q == StRdId) || (state_q == StRdTs);
        avm_address = (state_q == StRdTs);
        busy        = (state_q == StRdId) || (state_q == StRdTs) || (state_q == StCheck);
        done        = (state_q == StDone);
    end

    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a stalling system-ID slave model plus a reference
// model that predicts latency, strobe counts and result flags per check.
module tb_sysid_checker;

    localparam logic [31:0] ExpId = 32'd0;
    localparam logic [31:0] ExpTs = 32'd1488914704;
    localparam int          Tmo   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    // Slave model: stall w0/w1 cycles per read, junk data while stalled.
    logic [31:0] id_word = 32'd0;
    logic [31:0] ts_word = ExpTs;
    int          w0 = 0;
    int          w1 = 0;
    int          stall_cnt = 0;
    logic [31:0] good_data;

    assign good_data       = avm_address ? ts_word : id_word;
    assign avm_waitrequest = avm_read && (stall_cnt < (avm_address ? w1 : w0));
    assign avm_readdata    = avm_waitrequest ? ~good_data : good_data;

    always @(posedge clock) stall_cnt <= (avm_read && avm_waitrequest) ? stall_cnt + 1 : 0;

    always #5 clock = ~clock;

    sysid_checker #(
        .EXPECTED_ID       (ExpId),
        .EXPECTED_TIMESTAMP(ExpTs),
        .TIMEOUT_CYCLES    (Tmo),
        .AUTO_START        (1'b1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .done           (done),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .timeout        (timeout),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    int total = 0;
    int bad   = 0;

    // Reference model outputs; e_idv/e_tsv persist across checks like the DUT registers.
    int          e_lat, e_n0, e_n1;
    logic        e_id_ok, e_ts_ok, e_to;
    logic [31:0] e_idv = 32'd0;
    logic [31:0] e_tsv = 32'd0;

    // Latency counts edges from (and including) the one that accepts the start.
    task automatic predict();
        e_id_ok = 1'b0;
        e_ts_ok = 1'b0;
        if (w0 >= Tmo) begin
            e_lat = 1 + Tmo;
            e_n0  = Tmo;
            e_n1  = 0;
            e_to  = 1'b1;
        end else if (w1 >= Tmo) begin
            e_lat = 1 + (w0 + 1) + Tmo;
            e_n0  = w0 + 1;
            e_n1  = Tmo;
            e_to  = 1'b1;
            e_idv = id_word;
        end else begin
            e_lat   = 1 + (w0 + 1) + (w1 + 1) + 1;
            e_n0    = w0 + 1;
            e_n1    = w1 + 1;
            e_to    = 1'b0;
            e_idv   = id_word;
            e_tsv   = ts_word;
            e_id_ok = (id_word == ExpId);
            e_ts_ok = (ts_word == ExpTs);
        end
    endtask

    // Called at a negedge. Kicks a check by start pulse or by reset release and
    // measures it until done; extra_at injects a further start pulse mid-check.
    task automatic run_check(input bit by_reset, input int extra_at,
                             output int lat, output int n0, output int n1,
                             output bit proto_bad);
        bit   prev_stall;
        logic prev_addr;
        proto_bad  = 1'b0;
        n0         = 0;
        n1         = 0;
        prev_stall = 1'b0;
        prev_addr  = 1'b0;
        if (by_reset) reset = 1'b0;
        else start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) proto_bad = 1'b1;
            if (prev_stall && avm_read && avm_address !== prev_addr) proto_bad = 1'b1;
            if (avm_read === 1'b1) begin
                if (avm_address) n1++;
                else n0++;
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            start      = (lat == extra_at);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        if (busy !== 1'b0 || avm_read !== 1'b0) proto_bad = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        total++;
        if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout} !== 7'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout});
        end
        total++;
        if (id_value !== 32'd0 || ts_value !== 32'd0) begin
            bad++;
            $display("FAIL reset_values got id=%h ts=%h exp 0/0", id_value, ts_value);
        end
    endtask

    task automatic test_auto_start();
        int lat, n0, n1;
        bit pb;
        id_word = ExpId;
        ts_word = ExpTs;
        w0 = 0;
        w1 = 0;
        predict();
        run_check(1'b1, -1, lat, n0, n1, pb);
        total++;
        if ({lat[7:0], n0[7:0], n1[7:0], pb, done, id_ok, ts_ok, timeout} !==
            {e_lat[7:0], e_n0[7:0], e_n1[7:0], 1'b0, 1'b1, e_id_ok, e_ts_ok, e_to}) begin
            bad++;
            $display("FAIL auto_start lat=%0d n0=%0d n1=%0d pb=%0d d/i/t/to=%b exp lat=%0d n0=%0d n1=%0d %b",
                     lat, n0, n1, pb, {done, id_ok, ts_ok, timeout}, e_lat, e_n0, e_n1,
                     {1'b1, e_id_ok, e_ts_ok, e_to});
        end
        total++;
        if (id_value !== e_idv || ts_value !== e_tsv) begin
            bad++;
            $display("FAIL auto_values got id=%h ts=%h exp id=%h ts=%h", id_value, ts_value,
                     e_idv, e_tsv);
        end
    endtask

    task automatic test_ts_mismatch();
        int lat, n0, n1;
        bit pb;
        ts_word = ExpTs + 32'd1;
        predict();
        run_check(1'b0, -1, lat, n0, n1, pb);
        total++;
        if ({lat[7:0], pb, done, id_ok, ts_ok, timeout} !==
            {e_lat[7:0], 1'b0, 1'b1, e_id_ok, e_ts_ok, e_to}) begin
            bad++;
            $display("FAIL ts_mismatch lat=%0d pb=%0d d/i/t/to=%b exp lat=%0d %b", lat, pb,
                     {done, id_ok, ts_ok, timeout}, e_lat, {1'b1, e_id_ok, e_ts_ok, e_to});
        end
        total++;
        if (ts_value !== e_tsv) begin
            bad++;
            $display("FAIL ts_mismatch_value got=%h exp=%h", ts_value, e_tsv);
        end
    endtask

    task automatic test_wait_states();
        int lat, n0, n1;
        bit pb;
        ts_word = ExpTs;
        w0 = 3;
        w1 = 3;
        predict();
        run_check(1'b0, -1, lat, n0, n1, pb);
        total++;
        if ({lat[7:0], n0[7:0], n1[7:0], pb, done, id_ok, ts_ok, timeout} !==
            {e_lat[7:0], e_n0[7:0], e_n1[7:0], 1'b0, 1'b1, e_id_ok, e_ts_ok, e_to}) begin
            bad++;
            $display("FAIL wait_states lat=%0d n0=%0d n1=%0d pb=%0d flags=%b exp lat=%0d n0=%0d n1=%0d %b",
                     lat, n0, n1, pb, {done, id_ok, ts_ok, timeout}, e_lat, e_n0, e_n1,
                     {1'b1, e_id_ok, e_ts_ok, e_to});
        end
        total++;
        if (id_value !== e_idv || ts_value !== e_tsv) begin
            bad++;
            $display("FAIL wait_values got id=%h ts=%h exp id=%h ts=%h", id_value, ts_value,
                     e_idv, e_tsv);
        end
    endtask

    task automatic test_timeouts();
        int lat, n0, n1;
        bit pb;
        for (int k = 0; k < 2; k++) begin
            id_word = 32'h1234_5678 + k;
            w0 = (k == 0) ? 1000 : 1;
            w1 = (k == 0) ? 0 : 1000;
            predict();
            run_check(1'b0, -1, lat, n0, n1, pb);
            total++;
            if ({lat[7:0], n0[7:0], n1[7:0], pb, done, id_ok, ts_ok, timeout} !==
                {e_lat[7:0], e_n0[7:0], e_n1[7:0], 1'b0, 1'b1, e_id_ok, e_ts_ok, e_to}) begin
                bad++;
                $display("FAIL timeout_%0d lat=%0d n0=%0d n1=%0d pb=%0d flags=%b exp lat=%0d n0=%0d n1=%0d %b",
                         k, lat, n0, n1, pb, {done, id_ok, ts_ok, timeout}, e_lat, e_n0, e_n1,
                         {1'b1, e_id_ok, e_ts_ok, e_to});
            end
            total++;
            if (id_value !== e_idv || ts_value !== e_tsv) begin
                bad++;
                $display("FAIL timeout_%0d_values got id=%h ts=%h exp id=%h ts=%h", k,
                         id_value, ts_value, e_idv, e_tsv);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, n0, n1;
        bit pb;
        id_word = ExpId;
        ts_word = ExpTs;
        w0 = 0;
        w1 = 0;
        predict();
        run_check(1'b0, 2, lat, n0, n1, pb);
        total++;
        if ({lat[7:0], n0[7:0], n1[7:0], pb, id_ok, ts_ok, timeout} !==
            {e_lat[7:0], e_n0[7:0], e_n1[7:0], 1'b0, e_id_ok, e_ts_ok, e_to}) begin
            bad++;
            $display("FAIL busy_start lat=%0d n0=%0d n1=%0d pb=%0d exp lat=%0d n0=%0d n1=%0d",
                     lat, n0, n1, pb, e_lat, e_n0, e_n1);
        end
        repeat (3) @(negedge clock);
        total++;
        if ({done, busy, avm_read} !== 3'b100) begin
            bad++;
            $display("FAIL busy_start_single got d/b/r=%b exp 100", {done, busy, avm_read});
        end
        predict();
        run_check(1'b0, -1, lat, n0, n1, pb);
        total++;
        if ({lat[7:0], pb, done, id_ok, ts_ok} !== {e_lat[7:0], 1'b0, 1'b1, e_id_ok, e_ts_ok}) begin
            bad++;
            $display("FAIL rerun lat=%0d pb=%0d flags=%b exp lat=%0d", lat, pb,
                     {done, id_ok, ts_ok}, e_lat);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat, n0, n1;
        bit pb;
        w0 = 0;
        w1 = 1000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        total++;
        if ({avm_read, avm_address, avm_waitrequest} !== 3'b111) begin
            bad++;
            $display("FAIL mid_read_setup got r/a/w=%b exp 111",
                     {avm_read, avm_address, avm_waitrequest});
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout} !== 7'd0 ||
            id_value !== 32'd0 || ts_value !== 32'd0) begin
            bad++;
            $display("FAIL mid_read_reset got ctrl=%b id=%h ts=%h exp all 0",
                     {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, id_value,
                     ts_value);
        end
        e_idv = 32'd0;
        e_tsv = 32'd0;
        w1 = 0;
        predict();
        run_check(1'b1, -1, lat, n0, n1, pb);
        total++;
        if ({lat[7:0], n0[7:0], n1[7:0], pb, done, id_ok, ts_ok, timeout} !==
            {e_lat[7:0], e_n0[7:0], e_n1[7:0], 1'b0, 1'b1, e_id_ok, e_ts_ok, e_to}) begin
            bad++;
            $display("FAIL mid_read_recheck lat=%0d n0=%0d n1=%0d pb=%0d flags=%b exp lat=%0d %b",
                     lat, n0, n1, pb, {done, id_ok, ts_ok, timeout}, e_lat,
                     {1'b1, e_id_ok, e_ts_ok, e_to});
        end
    endtask

    task automatic test_random();
        int lat, n0, n1;
        bit pb;
        for (int i = 0; i < 24; i++) begin
            id_word = ($urandom_range(0, 1) == 1) ? ExpId : $urandom;
            ts_word = ($urandom_range(0, 1) == 1) ? ExpTs : $urandom;
            w0 = $urandom_range(0, 9);
            w1 = $urandom_range(0, 9);
            predict();
            run_check(1'b0, -1, lat, n0, n1, pb);
            total++;
            if ({lat[7:0], n0[7:0], n1[7:0], pb, done, id_ok, ts_ok, timeout} !==
                {e_lat[7:0], e_n0[7:0], e_n1[7:0], 1'b0, 1'b1, e_id_ok, e_ts_ok, e_to}) begin
                bad++;
                $display("FAIL random_%0d w0=%0d w1=%0d lat=%0d n0=%0d n1=%0d pb=%0d flags=%b exp lat=%0d n0=%0d n1=%0d %b",
                         i, w0, w1, lat, n0, n1, pb, {done, id_ok, ts_ok, timeout}, e_lat,
                         e_n0, e_n1, {1'b1, e_id_ok, e_ts_ok, e_to});
            end
            total++;
            if (id_value !== e_idv || ts_value !== e_tsv) begin
                bad++;
                $display("FAIL random_%0d_values got id=%h ts=%h exp id=%h ts=%h", i,
                         id_value, ts_value, e_idv, e_tsv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_ts_mismatch();
        test_wait_states();
        test_timeouts();
        test_start_while_busy();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
